// File: rtl/cube_root_if.sv
// ----------------------------------------------------------------------------
// cube_root_if
// Operand and result handshakes of the cube-root unit, bundled so the unit
// and its driver share one definition of the widths.
//
// Signals
//   in_valid   operand valid                   (master -> slave)
//   in_ready   unit can accept an operand      (slave  -> master)
//   in_x       WIDTH-bit unsigned operand      (master -> slave)
//   out_valid  result valid                    (slave  -> master)
//   out_ready  downstream accepts the result   (master -> slave)
//   out_root   floor(cbrt(in_x)), ROOT_W bits  (slave  -> master)
//   out_rem    in_x - out_root^3, WIDTH bits   (slave  -> master)
// ----------------------------------------------------------------------------
interface cube_root_if #(
    parameter int WIDTH = 32
);
    localparam int ROOT_W = (WIDTH + 2) / 3;

    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_x;
    logic              out_valid;
    logic              out_ready;
    logic [ROOT_W-1:0] out_root;
    logic [WIDTH-1:0]  out_rem;

    modport master (
        output in_valid, in_x, out_ready,
        input  in_ready, out_valid, out_root, out_rem
    );

    modport slave (
        input  in_valid, in_x, out_ready,
        output in_ready, out_valid, out_root, out_rem
    );
endinterface

// File: rtl/cube_root.sv
// ----------------------------------------------------------------------------
// cube_root
// Iterative unsigned integer cube root. Produces floor(cbrt(x)) and the
// remainder x - root^3, one root bit per clock, using a restoring
// digit-by-digit recurrence (no multiplier array on the operand width).
//
// Ports
//   clk    sole clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    cube_root_if.slave: in_valid/in_ready/in_x operand handshake,
//          out_valid/out_ready/out_root/out_rem result handshake
//
// State | meaning
// ------+-------------------------------------------------------------
// IDLE  | in_ready high, waiting for an operand
// CALC  | one root bit per cycle, ITER cycles, counter runs ITER-1 -> 0
// DONE  | out_valid high, result held until out_ready
// ----------------------------------------------------------------------------
module cube_root #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    cube_root_if.slave  bus
);
    localparam int ITER   = (WIDTH + 2) / 3;
    localparam int ROOT_W = ITER;
    localparam int CNT_W  = $clog2(ITER) + 1;
    localparam int SH_W   = $clog2(3 * ITER) + 1;
    // b = 3*y2*(y2+1)+1 with y2 < 2^(ROOT_W+1) fits in 2*ROOT_W+4 bits;
    // the compare runs at the wider of that and the operand width.
    localparam int B_W    = 2 * ROOT_W + 4;
    localparam int CMP_W  = (B_W > WIDTH) ? B_W : WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0]  rem_q;
    logic [ROOT_W-1:0] y_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ROOT_W-1:0] root_q;
    logic [WIDTH-1:0]  out_rem_q;

    logic              in_ready_s;
    logic              out_valid_s;
    logic              accept;
    logic              last_iter;

    logic [SH_W-1:0]   shamt;
    logic [CMP_W-1:0]  y2;
    logic [CMP_W-1:0]  b;
    logic [CMP_W-1:0]  rem_sh;
    logic              take;
    logic [WIDTH-1:0]  rem_nxt;
    logic [ROOT_W-1:0] y_nxt;

    assign accept    = in_ready_s && bus.in_valid;
    assign last_iter = (cnt_q == '0);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_s = 1'b1;
                if (bus.in_valid) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                if (last_iter) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid_s = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------- iteration
    // The remainder is shifted down for the compare so that b<<s is only
    // ever subtracted when it is known to be <= rem_q and cannot overflow.
    always_comb begin
        shamt   = SH_W'(cnt_q) * SH_W'(3);
        y2      = CMP_W'({y_q, 1'b0});
        b       = CMP_W'(3) * y2 * (y2 + CMP_W'(1)) + CMP_W'(1);
        rem_sh  = CMP_W'(rem_q >> shamt);
        take    = (rem_sh >= b);
        rem_nxt = rem_q;
        y_nxt   = ROOT_W'(y2);
        if (take) begin
            rem_nxt = rem_q - WIDTH'(b << shamt);
            y_nxt   = ROOT_W'(y2 + CMP_W'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q     <= '0;
            y_q       <= '0;
            cnt_q     <= '0;
            root_q    <= '0;
            out_rem_q <= '0;
        end else begin
            if (accept) begin
                rem_q <= bus.in_x;
                y_q   <= '0;
                cnt_q <= CNT_W'(ITER - 1);
            end else if (state_q == CALC) begin
                rem_q <= rem_nxt;
                y_q   <= y_nxt;
                if (last_iter) begin
                    root_q    <= y_nxt;
                    out_rem_q <= rem_nxt;
                end else begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.out_root  = root_q;
    assign bus.out_rem   = out_rem_q;

endmodule

// File: tb/tb_cube_root.sv
// ----------------------------------------------------------------------------
// tb_cube_root
// Scoreboard bench for cube_root at WIDTH=32. The driver pushes the expected
// result when an operand is accepted; a monitor pops and compares on every
// output handshake, and also checks latency from acceptance to out_valid.
// ----------------------------------------------------------------------------
module tb_cube_root;
    localparam int WIDTH = 32;

    typedef struct {
        longint unsigned x;
        longint unsigned root;
        longint unsigned rem;
        longint          acc;
    } exp_t;

    logic   clk;
    logic   rst_n;
    longint cyc = 0;
    int     n_checks = 0;
    int     n_fail = 0;
    exp_t   exp_q[$];
    longint last_acc = 0;
    bit     prev_valid = 0;

    cube_root_if #(.WIDTH(WIDTH)) bus ();

    cube_root #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input bit ok, input string name,
                                  input longint unsigned act, input longint unsigned req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic void check_eq(input string name, input longint unsigned act,
                                     input longint unsigned req);
        check(act == req, name, act, req);
    endfunction

    // Reference: largest r with r^3 <= x, by binary search over cubes.
    function automatic longint unsigned ref_root(input longint unsigned x);
        longint unsigned lo = 0;
        longint unsigned hi = 2048;
        longint unsigned mid;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid * mid <= x) lo = mid;
            else hi = mid;
        end
        return lo;
    endfunction

    // Offer one operand and push its expectation at the accepting edge.
    // use_model=0 takes the caller's constants as the expectation.
    task automatic issue(input longint unsigned x, input bit use_model,
                         input longint unsigned root_c, input longint unsigned rem_c,
                         input bit keep_valid);
        int   waited = 0;
        exp_t e;
        bus.in_valid = 1'b1;
        bus.in_x     = x[WIDTH-1:0];
        while (!bus.in_ready && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!bus.in_ready) begin
            check(1'b0, "accept_timeout", 0, 1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        e.x = x;
        if (use_model) begin
            e.root = ref_root(x);
            e.rem  = x - e.root * e.root * e.root;
        end else begin
            e.root = root_c;
            e.rem  = rem_c;
        end
        e.acc    = cyc;
        last_acc = cyc;
        exp_q.push_back(e);
        if (!keep_valid) bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int w = 0;
        while ((exp_q.size() != 0 || !bus.in_ready) && w < 300) begin
            @(posedge clk); #1;
            w++;
        end
        check_eq("drain_queue_empty", exp_q.size(), 0);
    endtask

    // ------------------------------------------------------------ monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (bus.out_valid && !prev_valid) begin
                check_eq("no_spurious_valid", exp_q.size() > 0, 1);
                if (exp_q.size() > 0)
                    check_eq("latency", cyc - exp_q[0].acc, 11);
            end
            if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
                exp_t            e;
                longint unsigned r;
                e = exp_q.pop_front();
                r = bus.out_root;
                check_eq("root", r, e.root);
                check_eq("rem", bus.out_rem, e.rem);
                check((r * r * r <= e.x) && ((r + 1) * (r + 1) * (r + 1) > e.x),
                      "root_bounds", r, e.root);
            end
            prev_valid = bus.out_valid;
        end
    end

    // ------------------------------------------------------------- driver
    initial begin
        longint unsigned hr;
        longint unsigned hm;
        longint unsigned x;
        longint unsigned a;
        longint          prev_acc;
        int              w;
        bit              stray;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", bus.in_ready, 1);
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_out_root", bus.out_root, 0);
        check_eq("rst_out_rem", bus.out_rem, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(27, 0, 3, 0, 0);                    wait_drain();
        issue(26, 0, 2, 18, 0);                   wait_drain();
        issue(0, 0, 0, 0, 0);                     wait_drain();
        issue(1, 0, 1, 0, 0);                     wait_drain();
        issue(64'hFFFF_FFFF, 0, 1625, 3951670, 0); wait_drain();
        issue(999999999, 0, 999, 2997000, 0);     wait_drain();
        issue(1000000000, 0, 1000, 0, 0);         wait_drain();

        // Backpressure: result must hold and stray operands be ignored.
        bus.out_ready = 1'b0;
        issue(123456789, 1, 0, 0, 0);
        w = 0;
        while (!bus.out_valid && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        check_eq("bp_out_valid", bus.out_valid, 1);
        hr = bus.out_root;
        hm = bus.out_rem;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                bus.in_valid = 1'b1;
                bus.in_x     = 32'd8;
            end
            if (i == 6) bus.in_valid = 1'b0;
            @(posedge clk); #1;
            check_eq("bp_root_hold", bus.out_root, hr);
            check_eq("bp_rem_hold", bus.out_rem, hm);
            check_eq("bp_in_ready_low", bus.in_ready, 0);
            check_eq("bp_valid_hold", bus.out_valid, 1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("bp_release_in_ready", bus.in_ready, 1);
        check_eq("bp_release_out_valid", bus.out_valid, 0);
        wait_drain();

        // Reset during the 5th CALC cycle.
        issue(12345, 1, 0, 0, 0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check_eq("midrst_out_valid", bus.out_valid, 0);
        check_eq("midrst_in_ready", bus.in_ready, 1);
        check_eq("midrst_out_root", bus.out_root, 0);
        check_eq("midrst_out_rem", bus.out_rem, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        stray = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) stray = 1'b1;
        end
        check_eq("midrst_no_stray_valid", stray, 0);
        issue(64, 0, 4, 0, 0);
        wait_drain();

        // Random, issued back to back with in_valid held high.
        prev_acc = 0;
        for (int i = 0; i < 3000; i++) begin
            a = $urandom_range(0, 1625);
            case ($urandom_range(0, 3))
                0:       x = {32'd0, $urandom};
                1:       x = a * a * a;
                2:       x = (a == 0) ? 0 : a * a * a - 1;
                default: x = $urandom_range(0, 4096);
            endcase
            issue(x, 1, 0, 0, 1);
            if (i > 0) check_eq("initiation_interval", last_acc - prev_acc, 13);
            prev_acc = last_acc;
        end
        bus.in_valid = 1'b0;
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
